// File: rtl/prover_ctrl_pkg.sv
// rtl/prover_ctrl_pkg.sv - shared types and constants for the prover round controller
package prover_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_RND,
    ST_ISSUE_W0,
    ST_WAIT_W0,
    ST_ERR
  } ctrl_state_e;

  // Prover status codes: 0x means more rounds remain, 1x means sumcheck is complete.
  localparam logic [1:0] READY_CODE_MORE0 = 2'b00;
  localparam logic [1:0] READY_CODE_MORE1 = 2'b01;
  localparam logic [1:0] READY_CODE_DONE0 = 2'b10;
  localparam logic [1:0] READY_CODE_DONE1 = 2'b11;

  // Two rounds per input bit (left and right wire) plus one per gate bit.
  function automatic int nrounds(input int ninbits, input int ngatebits);
    return 2 * ninbits + ngatebits;
  endfunction

endpackage

// File: rtl/prover_round_ctrl_if.sv
// rtl/prover_round_ctrl_if.sv - challenge source and prover handshake bundle
interface prover_round_ctrl_if #(
  parameter int F_NBITS = 16
);
  logic               start;
  logic [F_NBITS-1:0] chal;
  logic               chal_valid;
  logic               chal_ready;
  logic               ready_pulse;
  logic [1:0]         ready_code;
  logic               w0_ready_pulse;
  logic               en;
  logic               restart;
  logic               comp_w0;
  logic [F_NBITS-1:0] tau;
  logic [F_NBITS-1:0] tau_w0;
  logic               busy;
  logic               done;
  logic               err;
  logic [7:0]         round_cnt;
  logic [31:0]        cycle_cnt;

  modport master (
    input  start, chal, chal_valid, ready_pulse, ready_code, w0_ready_pulse,
    output chal_ready, en, restart, comp_w0, tau, tau_w0, busy, done, err,
           round_cnt, cycle_cnt
  );

  modport slave (
    output start, chal, chal_valid, ready_pulse, ready_code, w0_ready_pulse,
    input  chal_ready, en, restart, comp_w0, tau, tau_w0, busy, done, err,
           round_cnt, cycle_cnt
  );
endinterface

// File: rtl/prover_tau_prefetch.sv
// rtl/prover_tau_prefetch.sv - one-entry challenge holding slot with fall-through
module prover_tau_prefetch #(
  parameter int F_NBITS = 16
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               flush_i,
  input  logic               enable_i,
  input  logic [F_NBITS-1:0] in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [F_NBITS-1:0] out_data_o,
  output logic               out_valid_o,
  input  logic               out_pop_i
);
  logic               full_q;
  logic [F_NBITS-1:0] data_q;

  // An arriving value is usable in the same cycle so an empty slot costs no extra latency.
  assign in_ready_o  = enable_i & ~full_q;
  assign out_valid_o = full_q | (in_valid_i & in_ready_o);
  assign out_data_o  = full_q ? data_q : in_data_i;

  // Capture unless consumed on the fly; a pop of a held value empties the slot.
  always_ff @(posedge clk) begin
    if (!rstb || flush_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid_i && in_ready_o && !out_pop_i) begin
      full_q <= 1'b1;
      data_q <= in_data_i;
    end else if (out_pop_i) begin
      full_q <= 1'b0;
    end
  end
endmodule

// File: rtl/prover_round_ctrl.sv
// rtl/prover_round_ctrl.sv - sequences a sumcheck prover through a complete proof
module prover_round_ctrl
  import prover_ctrl_pkg::*;
#(
  parameter int NINBITS   = 3,
  parameter int NGATEBITS = 3,
  parameter int TIMEOUT   = 65535,
  parameter int F_NBITS   = 16
) (
  input logic                 clk,
  input logic                 rstb,
  prover_round_ctrl_if.master bus
);
  localparam logic [7:0]  LAST_ROUND  = 8'(nrounds(NINBITS, NGATEBITS));
  localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT);

  ctrl_state_e        state_q, state_d;
  logic               en_q, en_d, restart_q, restart_d, comp_w0_q, comp_w0_d;
  logic               done_q, done_d, busy_q, busy_d, err_q, err_d;
  logic               w0_pend_q, w0_pend_d;
  logic [F_NBITS-1:0] tau_q, tau_d, tau_w0_q, tau_w0_d;
  logic [7:0]         round_cnt_q, round_cnt_d;
  logic [31:0]        cycle_cnt_q, cycle_cnt_d, wait_cnt_q, wait_cnt_d;

  logic               slot_valid, slot_pop, slot_flush, slot_in_ready;
  logic [F_NBITS-1:0] slot_data;
  logic               is_final, last_round, pulse_err, fail, issue_rnd, issue_w0;

  prover_tau_prefetch #(.F_NBITS(F_NBITS)) u_prefetch (
    .clk        (clk),
    .rstb       (rstb),
    .flush_i    (slot_flush),
    .enable_i   (busy_q),
    .in_data_i  (bus.chal),
    .in_valid_i (bus.chal_valid),
    .in_ready_o (slot_in_ready),
    .out_data_o (slot_data),
    .out_valid_o(slot_valid),
    .out_pop_i  (slot_pop)
  );

  assign is_final   = (bus.ready_code == READY_CODE_DONE0) || (bus.ready_code == READY_CODE_DONE1);
  assign last_round = (round_cnt_q == LAST_ROUND);
  assign pulse_err  = (bus.ready_pulse && state_q != ST_WAIT_RND) ||
                      (bus.w0_ready_pulse && state_q != ST_WAIT_W0) ||
                      (bus.ready_pulse && bus.w0_ready_pulse);

  // Next state, pulse outputs and counters; pulses are computed one cycle ahead and registered.
  always_comb begin
    state_d     = state_q;
    en_d        = 1'b0;
    restart_d   = 1'b0;
    comp_w0_d   = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    w0_pend_d   = w0_pend_q;
    tau_d       = tau_q;
    tau_w0_d    = tau_w0_q;
    round_cnt_d = round_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    slot_pop    = 1'b0;
    slot_flush  = 1'b0;
    fail        = 1'b0;
    issue_rnd   = 1'b0;
    issue_w0    = 1'b0;

    // Counts busy cycles before the done cycle, i.e. from the cycle after start up to done.
    if (busy_q && !done_q && cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 32'd1;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (bus.start) begin
          state_d     = ST_FETCH;
          slot_flush  = 1'b1;
          err_d       = 1'b0;
          w0_pend_d   = 1'b0;
          round_cnt_d = '0;
          cycle_cnt_d = '0;
        end else if (state_q == ST_IDLE && pulse_err) begin
          fail = 1'b1;
        end
      end
      ST_FETCH: begin
        if (pulse_err) fail = 1'b1;
        else if (slot_valid) begin
          slot_pop  = 1'b1;
          issue_w0  = w0_pend_q;
          issue_rnd = ~w0_pend_q;
        end
      end
      ST_ISSUE: begin
        if (pulse_err) fail = 1'b1;
        else state_d = ST_WAIT_RND;
      end
      ST_WAIT_RND: begin
        if (pulse_err) fail = 1'b1;
        else if (bus.ready_pulse) begin
          if (is_final != last_round) fail = 1'b1;
          else begin
            w0_pend_d = is_final;
            if (slot_valid) begin
              slot_pop  = 1'b1;
              issue_w0  = is_final;
              issue_rnd = ~is_final;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end else if (wait_cnt_q >= TIMEOUT_CYC) fail = 1'b1;
        else wait_cnt_d = wait_cnt_q + 32'd1;
      end
      ST_ISSUE_W0: begin
        if (pulse_err) fail = 1'b1;
        else state_d = ST_WAIT_W0;
      end
      ST_WAIT_W0: begin
        if (pulse_err) fail = 1'b1;
        else if (bus.w0_ready_pulse) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (wait_cnt_q >= TIMEOUT_CYC) fail = 1'b1;
        else wait_cnt_d = wait_cnt_q + 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // The wait counter holds cycles elapsed since the pulse the prover must answer.
    if (issue_rnd) begin
      state_d     = ST_ISSUE;
      en_d        = 1'b1;
      restart_d   = (round_cnt_q == 8'd0);
      tau_d       = slot_data;
      round_cnt_d = round_cnt_q + 8'd1;
      wait_cnt_d  = 32'd1;
    end
    if (issue_w0) begin
      state_d    = ST_ISSUE_W0;
      comp_w0_d  = 1'b1;
      tau_w0_d   = slot_data;
      wait_cnt_d = 32'd1;
    end
    if (fail) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
    end

    // Busy stays up through the done cycle itself.
    busy_d = (state_d != ST_IDLE && state_d != ST_ERR) || done_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      en_q        <= 1'b0;
      restart_q   <= 1'b0;
      comp_w0_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      w0_pend_q   <= 1'b0;
      tau_q       <= '0;
      tau_w0_q    <= '0;
      round_cnt_q <= '0;
      cycle_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      restart_q   <= restart_d;
      comp_w0_q   <= comp_w0_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      w0_pend_q   <= w0_pend_d;
      tau_q       <= tau_d;
      tau_w0_q    <= tau_w0_d;
      round_cnt_q <= round_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.chal_ready = slot_in_ready;
  assign bus.en         = en_q;
  assign bus.restart    = restart_q;
  assign bus.comp_w0    = comp_w0_q;
  assign bus.tau        = tau_q;
  assign bus.tau_w0     = tau_w0_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.round_cnt  = round_cnt_q;
  assign bus.cycle_cnt  = cycle_cnt_q;
endmodule
